montgomery_mult_param: RTL
==========================

// Module: montgomery_mult_param
// PURPOSE
//  Parametrised radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod m.
//  Generalises the fixed 1024-bit multiplier to any WIDTH, and adds busy, error and
//  abort behaviour. It is the modular-multiply engine under the RSA exponentiation
//  controller: one start/done transaction per multiplication.
// PARAMETERS
//  WIDTH   1024  operand/modulus width in bits (>=4); also the Montgomery exponent R=2^WIDTH
// PORTS
//  clk     in   1      single clock, rising edge
//  resetn  in   1      asynchronous active-low reset
//  start   in   1      1-cycle request; sampled only in IDLE
//  abort   in   1      synchronous cancel of a running operation
//  in_a    in   WIDTH  multiplicand, must be < in_m
//  in_b    in   WIDTH  multiplier, must be < in_m
//  in_m    in   WIDTH  modulus, must be odd
//  result  out  WIDTH  a*b*R^-1 mod m; valid from done, held until next accepted start
//  done    out  1      1-cycle pulse: result (or error) valid
//  busy    out  1      high from the cycle after start is accepted until done
//  err     out  1      high with done if in_m was even; held until next accepted start
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE; result=0, done=0, busy=0, err=0; internal regs cleared.
//  States: IDLE -> LOOP -> SUB -> FIN -> IDLE.
//  IDLE: on start=1 latch a,b,m into registers; clear C; i=0; err=0; busy=1 next cycle.
//    If in_m[0]==0: go directly to FIN with err=1 and result=0 (no iterations).
//  LOOP: one iteration per cycle, i=0..WIDTH-1:
//    C <= (C + a[i]*B + q*M) >> 1, where q = LSB of (C + a[i]*B).
//    C is held at WIDTH+2 bits; the invariant C < 2m holds for a,b < m.
//    After i==WIDTH-1 -> SUB.
//  SUB: if C >= M then result <= C-M, else result <= C (low WIDTH bits) -> FIN.
//  FIN: done=1 for exactly one cycle, busy=0 in the same cycle -> IDLE.
//  Latency: start accepted at cycle 0; done at cycle WIDTH+2 (LOOP cycles 1..WIDTH,
//    SUB cycle WIDTH+1). For even m, done at cycle 1.
//  start while busy: ignored, with no effect on the running operation or its operands.
//  start in the same cycle as FIN: ignored (FIN is not IDLE).
//  abort in LOOP/SUB: return to IDLE next cycle; busy=0, done is not pulsed, and result
//    keeps its previous value. abort in IDLE/FIN: no effect.
//  in_a/in_b/in_m may change freely after the start cycle.
//  Out-of-range operands (a or b >= m): result is undefined but done still occurs on time.
//  Async reset mid-operation: immediate return to reset values; no done pulse.
// STRUCTURE
//  montgomery_pkg: state enum (IDLE, LOOP, SUB, FIN), localparam function
//    MONT_LATENCY(W)=W+2, and the counter-width helper $clog2(WIDTH).
//  Sub-module mont_iter_step (combinational, parametrised WIDTH): takes C, a_bit, B, M
//    and returns the next C. This isolates the critical adder path for later CSA or
//    pipelined replacement.
//  Top level: FSM, iteration counter, operand shift register for a, final subtractor.
// TESTING
//  WIDTH=8: a=5, b=7, m=13 -> result=8'h01 (35*9^-1 mod 13), done at start+10.
//  WIDTH=8: a=254, b=254, m=255 -> result=8'h01; exercises C near 2m and the final subtract.
//  WIDTH=1024: a=1, b=2, m=3 -> result=2; a=0x1BA, b=0x91B with the standard 1024-bit
//    test modulus -> compared against the C golden model; done exactly 1026 cycles after start.
//  WIDTH=8: m=12 (even) -> done at start+1 with err=1 and result=0; the next valid op clears err.
//  WIDTH=8: start pulsed mid-LOOP with different operands -> ignored, first result unchanged;
//    abort at iteration 3 -> no done, busy=0 next cycle, then a fresh op completes correctly.
//  resetn deasserted mid-LOOP -> all outputs at reset values asynchronously; a new op after
//    reset completes with the correct result.

Source files
------------

// File: rtl/montgomery_pkg.sv
// rtl/montgomery_pkg.sv - shared types and sizing helpers for the Montgomery multiplier
package montgomery_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    SUB  = 2'd2,
    FIN  = 2'd3
  } mont_state_e;

  // Cycles from accepted start to the done pulse for a valid (odd) modulus.
  function automatic int MONT_LATENCY(input int w);
    return w + 2;
  endfunction

  // Width of the iteration counter that walks bit 0..w-1 of the multiplicand.
  function automatic int mont_cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/mont_iter_step.sv
// rtl/mont_iter_step.sv - one radix-2 Montgomery iteration, C' = (C + a_i*B + q*M) / 2
module mont_iter_step #(
  parameter int WIDTH = 1024
) (
  input  logic [WIDTH+1:0] c_i,
  input  logic             a_bit_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH+1:0] c_o
);

  logic [WIDTH+1:0] sum_ab;
  logic [WIDTH+1:0] sum_abm;

  // Add a_i*B, then add M when the partial sum is odd so the halving is exact.
  // With C < 2M and B < M the sum stays below 4M, so WIDTH+2 bits never overflow.
  always_comb begin
    sum_ab  = c_i + (a_bit_i ? {2'b00, b_i} : '0);
    sum_abm = sum_ab + (sum_ab[0] ? {2'b00, m_i} : '0);
    c_o     = {1'b0, sum_abm[WIDTH+1:1]};
  end

endmodule

// File: rtl/montgomery_mult_param.sv
// rtl/montgomery_mult_param.sv - radix-2 Montgomery multiplier, result = a*b*2^-WIDTH mod m
module montgomery_mult_param
  import montgomery_pkg::*;
#(
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int             CNT_W    = mont_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mont_state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;       // multiplicand, shifted right once per iteration
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH+1:0] c_q, c_d;       // running accumulator, kept below 2M
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic [WIDTH+1:0] c_next;
  logic [WIDTH+1:0] c_minus_m;

  mont_iter_step #(.WIDTH(WIDTH)) u_step (
    .c_i     (c_q),
    .a_bit_i (a_q[0]),
    .b_i     (b_q),
    .m_i     (m_q),
    .c_o     (c_next)
  );

  assign c_minus_m = c_q - {2'b00, m_q};

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath update; abort wins over progress in LOOP and SUB.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = in_a;
          b_d   = in_b;
          m_d   = in_m;
          c_d   = '0;
          cnt_d = '0;
          err_d = 1'b0;
          if (!in_m[0]) begin
            // Even modulus has no inverse of 2: report it without iterating.
            err_d    = 1'b1;
            result_d = '0;
            state_d  = FIN;
          end else begin
            state_d = LOOP;
          end
        end
      end
      LOOP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          c_d   = c_next;
          a_d   = a_q >> 1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = SUB;
          end
        end
      end
      SUB: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          result_d = (c_q >= {2'b00, m_q}) ? c_minus_m[WIDTH-1:0] : c_q[WIDTH-1:0];
          state_d  = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign done   = (state_q == FIN);
  assign busy   = (state_q == LOOP) || (state_q == SUB);
  assign err    = err_q;
  assign result = result_q;

endmodule
